// File: rtl/write_addr_gen.sv
// +--------------------------------------------------------------------------+
// | Module   : write_addr_gen                                                |
// | Function : expands one AW command into len+1 per-beat write addresses   |
// |            (FIXED / INCR / WRAP) with per-burst illegal-command flag.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module write_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 6,
  parameter int DATA_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [2:0]        cmd_prot,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [ID_W-1:0]   beat_id,
  output logic [2:0]        beat_prot,
  output logic [7:0]        beat_idx,
  output logic              beat_last,
  output logic              beat_err,
  output logic              busy
);

  localparam logic [2:0]        c_MAX_SIZE = 3'($clog2(DATA_BYTES));
  localparam logic [1:0]        c_FIXED    = 2'b00;
  localparam logic [1:0]        c_INCR     = 2'b01;
  localparam logic [1:0]        c_WRAP     = 2'b10;
  localparam logic [1:0]        c_RSVD     = 2'b11;
  localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_beat_addr, r_incr, r_wrap_lower, r_wrap_upper;
  logic [ID_W-1:0]   r_beat_id;
  logic [2:0]        r_beat_prot;
  logic [7:0]        r_beat_idx, r_len;
  logic [1:0]        r_burst;
  logic              r_err;

  logic [ADDR_W-1:0] w_cmd_incr, w_cmd_wrap_bytes, w_cmd_wrap_lower;
  logic [ADDR_W-1:0] w_incr_sum, w_next_addr;
  logic              w_cmd_err, w_pop, w_fire, w_at_last;

  assign w_cmd_incr       = c_ONE << cmd_size;
  assign w_cmd_wrap_bytes = ADDR_W'({1'b0, cmd_len} + 9'd1) << cmd_size;
  assign w_cmd_wrap_lower = cmd_addr & ~(w_cmd_wrap_bytes - c_ONE);

  always_comb begin
    w_cmd_err = 1'b0;
    if (cmd_size > c_MAX_SIZE)  w_cmd_err = 1'b1;
    if (cmd_burst == c_RSVD)    w_cmd_err = 1'b1;
    if (cmd_burst == c_WRAP) begin
      if (!(cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15))
        w_cmd_err = 1'b1;
      if ((cmd_addr & (w_cmd_incr - c_ONE)) != '0)
        w_cmd_err = 1'b1;
    end
  end

  // Illegal bursts keep the start address on every beat.
  assign w_incr_sum = r_beat_addr + r_incr;
  always_comb begin
    w_next_addr = r_beat_addr;
    if (!r_err) begin
      case (r_burst)
        c_INCR:  w_next_addr = (r_beat_addr & ~(r_incr - c_ONE)) + r_incr;
        c_WRAP:  w_next_addr = (w_incr_sum == r_wrap_upper) ? r_wrap_lower : w_incr_sum;
        c_FIXED: w_next_addr = r_beat_addr;
        default: w_next_addr = r_beat_addr;
      endcase
    end
  end

  assign w_at_last = (r_beat_idx == r_len);
  assign w_pop     = cmd_valid && cmd_ready;
  assign w_fire    = beat_valid && beat_ready;

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    beat_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) w_next_state = ST_BURST;
      end
      ST_BURST: begin
        beat_valid = 1'b1;
        busy       = 1'b1;
        if (beat_ready && w_at_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beat_addr  <= '0;
      r_beat_id    <= '0;
      r_beat_prot  <= '0;
      r_beat_idx   <= '0;
      r_len        <= '0;
      r_burst      <= '0;
      r_err        <= 1'b0;
      r_incr       <= '0;
      r_wrap_lower <= '0;
      r_wrap_upper <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) begin
        r_beat_addr  <= cmd_addr;
        r_beat_id    <= cmd_id;
        r_beat_prot  <= cmd_prot;
        r_beat_idx   <= 8'd0;
        r_len        <= cmd_len;
        r_burst      <= cmd_burst;
        r_err        <= w_cmd_err;
        r_incr       <= w_cmd_incr;
        r_wrap_lower <= w_cmd_wrap_lower;
        r_wrap_upper <= w_cmd_wrap_lower + w_cmd_wrap_bytes;
      end else if (w_fire && !w_at_last) begin
        r_beat_idx  <= r_beat_idx + 8'd1;
        r_beat_addr <= w_next_addr;
      end
    end
  end

  assign beat_addr = r_beat_addr;
  assign beat_id   = r_beat_id;
  assign beat_prot = r_beat_prot;
  assign beat_idx  = r_beat_idx;
  assign beat_last = beat_valid && w_at_last;
  assign beat_err  = beat_valid && r_err;

endmodule

`default_nettype wire
